// File: rtl/soc_sysid_checker.sv
// soc_sysid_checker
//
// Boot-time sequencer and host access arbiter for the system-ID peripheral.
// After reset, and again on each start pulse taken in IDLE, it does three things:
//   - reads the ID word (address 0) and the timestamp word (address 1);
//   - compares both against the build-time values;
//   - retries up to RETRIES extra passes if either word differs.
// While idle it passes host reads through to the same peripheral.
//
// Ports
//   clock, reset_n        system clock, synchronous active-low reset
//   start                 one-cycle pulse, re-runs the check (IDLE only)
//   sid_address           address to the sysid peripheral
//   sid_readdata          sysid data, combinational on sid_address
//   host_read/address     host Avalon-MM read request
//   host_waitrequest      combinational stall to the host
//   host_readdata/valid   registered read response, one cycle after accept
//   done, pass            sequence finished / both words matched
//   id_mismatch           ID word differed on the final pass
//   ts_mismatch           timestamp word differed on the final pass
//   retry_count           retries used by the last sequence
//   captured_id/ts        last words read by the sequencer
module soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_1110,
    parameter logic [31:0] EXPECTED_TS = 32'h5C2C_B16E,
    parameter int unsigned RETRIES     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    input  logic        host_read,
    input  logic        host_address,
    output logic        host_waitrequest,
    output logic [31:0] host_readdata,
    output logic        host_readdatavalid,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic [1:0]  retry_count,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [1:0] MAX_RETRY = 2'(RETRIES);

    typedef enum logic [1:0] {RD_ID, RD_TS, CHECK, IDLE} state_t;

    state_t state;
    logic   accept;
    logic   id_ok;
    logic   ts_ok;

    // start wins over a simultaneous host read, so the host is stalled
    // in that cycle even though the FSM is still in IDLE.
    assign host_waitrequest = !((state == IDLE) && !start);
    assign accept           = host_read && !host_waitrequest;

    assign id_ok = (captured_id == EXPECTED_ID);
    assign ts_ok = (captured_ts == EXPECTED_TS);

    always_comb begin
        sid_address = 1'b0;
        case (state)
            RD_ID:   sid_address = 1'b0;
            RD_TS:   sid_address = 1'b1;
            IDLE:    sid_address = host_address;
            default: sid_address = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state              <= RD_ID;
            done               <= 1'b0;
            pass               <= 1'b0;
            id_mismatch        <= 1'b0;
            ts_mismatch        <= 1'b0;
            retry_count        <= 2'd0;
            captured_id        <= 32'd0;
            captured_ts        <= 32'd0;
            host_readdata      <= 32'd0;
            host_readdatavalid <= 1'b0;
        end else begin
            host_readdatavalid <= accept;
            if (accept) begin
                host_readdata <= sid_readdata;
            end

            case (state)
                RD_ID: begin
                    captured_id <= sid_readdata;
                    state       <= RD_TS;
                end
                RD_TS: begin
                    captured_ts <= sid_readdata;
                    state       <= CHECK;
                end
                CHECK: begin
                    if (id_ok && ts_ok) begin
                        pass        <= 1'b1;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else if (retry_count < MAX_RETRY) begin
                        // Status stays as it was; only the final pass reports.
                        retry_count <= retry_count + 2'd1;
                        state       <= RD_ID;
                    end else begin
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        id_mismatch <= !id_ok;
                        ts_mismatch <= !ts_ok;
                        state       <= IDLE;
                    end
                end
                IDLE: begin
                    if (start) begin
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        retry_count <= 2'd0;
                        state       <= RD_ID;
                    end
                end
                default: state <= RD_ID;
            endcase
        end
    end

endmodule
